// File: rtl/vr_pack_pkg.sv
// rtl/vr_pack_pkg.sv - shared types and default sizes for the vr_pack stream upsizer
package vr_pack_pkg;

    localparam int VR_PACK_N = 4;
    localparam int VR_PACK_K = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } vr_pack_state_e;

endpackage

// File: rtl/vr_pack.sv
// rtl/vr_pack.sv - packs K narrow valid/ready beats into one wide word, double-buffered
module vr_pack
    import vr_pack_pkg::*;
#(
    parameter int N = VR_PACK_N,
    parameter int K = VR_PACK_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dwn_vld,
    input  logic [N-1:0]   dwn_data,
    input  logic           dwn_last,
    output logic           dwn_rdy,
    output logic           up_vld,
    output logic [N*K-1:0] up_data,
    output logic [K-1:0]   up_keep,
    output logic           up_last,
    input  logic           up_rdy
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;

    vr_pack_state_e r_state;
    vr_pack_state_e w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic [N*K-1:0] r_acc_data;
    logic [K-1:0]   r_acc_keep;
    logic           r_acc_last;
    logic [N*K-1:0] r_up_data;
    logic [K-1:0]   r_up_keep;
    logic           r_up_last;
    logic           r_dwn_rdy;

    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_complete;
    logic [K-1:0]   w_lane_sel;
    logic [N*K-1:0] w_word_data;
    logic [K-1:0]   w_word_keep;
    logic           w_load_new;
    logic           w_load_pend;
    logic           w_hold_pend;

    assign w_in_fire  = dwn_vld && r_dwn_rdy;
    assign w_out_fire = (r_state != EMPTY) && up_rdy;
    assign w_complete = w_in_fire && ((r_cnt == CW'(K - 1)) || dwn_last);

    // The word as it would look with the current beat merged into its lane;
    // lanes not yet written keep their cleared accumulator value (zero).
    genvar g;
    generate
        for (g = 0; g < K; g++) begin : g_lane
            assign w_lane_sel[g]             = w_in_fire && (r_cnt == CW'(g));
            assign w_word_data[g*N +: N]     = w_lane_sel[g] ? dwn_data : r_acc_data[g*N +: N];
            assign w_word_keep[g]            = w_lane_sel[g] | r_acc_keep[g];
        end
    endgenerate

    // Slot state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next-state and load selects: which word (new or pending) goes to the output
    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_pend = 1'b0;
        w_hold_pend = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = ONE;
                    w_load_new  = 1'b1;
                end
            end
            ONE: begin
                if (w_out_fire && w_complete) begin
                    w_load_new = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end else if (w_complete) begin
                    w_state_nxt = TWO;
                    w_hold_pend = 1'b1;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state_nxt = ONE;
                    w_load_pend = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // Accumulator and beat index; a completed word parks here only when the output is busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_load_pend) begin
                r_acc_data <= '0;
                r_acc_keep <= '0;
                r_acc_last <= 1'b0;
            end else if (w_hold_pend) begin
                r_acc_data <= w_word_data;
                r_acc_keep <= w_word_keep;
                r_acc_last <= dwn_last;
            end else if (w_complete) begin
                r_acc_data <= '0;
                r_acc_keep <= '0;
                r_acc_last <= 1'b0;
            end else if (w_in_fire) begin
                r_acc_data <= w_word_data;
                r_acc_keep <= w_word_keep;
            end

            if (w_complete) begin
                r_cnt <= '0;
            end else if (w_in_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register only changes on a load, so it holds still under back-pressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up_data <= '0;
            r_up_keep <= '0;
            r_up_last <= 1'b0;
        end else if (w_load_new) begin
            r_up_data <= w_word_data;
            r_up_keep <= w_word_keep;
            r_up_last <= dwn_last;
        end else if (w_load_pend) begin
            r_up_data <= r_acc_data;
            r_up_keep <= r_acc_keep;
            r_up_last <= r_acc_last;
        end
    end

    // Ready is registered from next-state so up_rdy never reaches dwn_rdy combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwn_rdy <= 1'b1;
        end else begin
            r_dwn_rdy <= (w_state_nxt != TWO);
        end
    end

    assign dwn_rdy = r_dwn_rdy;
    assign up_vld  = (r_state != EMPTY);
    assign up_data = r_up_data;
    assign up_keep = r_up_keep;
    assign up_last = r_up_last;

endmodule

// File: tb/tb_vr_pack.sv
// tb/tb_vr_pack.sv - directed and random self-checking bench for vr_pack
module tb_vr_pack;
    import vr_pack_pkg::*;

    localparam int N = VR_PACK_N;
    localparam int K = VR_PACK_K;

    logic           clk = 1'b0;
    logic           rst;
    logic           dwn_vld;
    logic [N-1:0]   dwn_data;
    logic           dwn_last;
    logic           dwn_rdy;
    logic           up_vld;
    logic [N*K-1:0] up_data;
    logic [K-1:0]   up_keep;
    logic           up_last;
    logic           up_rdy;

    int checks   = 0;
    int failures = 0;

    vr_pack #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .dwn_vld  (dwn_vld),
        .dwn_data (dwn_data),
        .dwn_last (dwn_last),
        .dwn_rdy  (dwn_rdy),
        .up_vld   (up_vld),
        .up_data  (up_data),
        .up_keep  (up_keep),
        .up_last  (up_last),
        .up_rdy   (up_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [N-1:0] d, input logic l);
        dwn_vld  = 1'b1;
        dwn_data = d;
        dwn_last = l;
        @(negedge clk);
    endtask

    task automatic idle();
        dwn_vld  = 1'b0;
        dwn_data = '0;
        dwn_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_word(input string tag, input logic [15:0] d, input logic [3:0] k, input logic l);
        check({tag, "_vld"},  32'(up_vld),  32'd1);
        check({tag, "_data"}, 32'(up_data), 32'(d));
        check({tag, "_keep"}, 32'(up_keep), 32'(k));
        check({tag, "_last"}, 32'(up_last), 32'(l));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_up_vld"},  32'(up_vld),  32'd0);
        check({tag, "_up_data"}, 32'(up_data), 32'd0);
        check({tag, "_up_keep"}, 32'(up_keep), 32'd0);
        check({tag, "_up_last"}, 32'(up_last), 32'd0);
        check({tag, "_dwn_rdy"}, 32'(dwn_rdy), 32'd1);
    endtask

    logic [N*K-1:0]     m_data;
    logic [K-1:0]       m_keep;
    int                 m_cnt;
    logic [N*K+K:0]     exp_q[$];
    logic [N*K+K:0]     hold;
    logic               stalled;
    int                 accepted;
    int                 words;

    initial begin
        rst      = 1'b0;
        dwn_vld  = 1'b0;
        dwn_data = '0;
        dwn_last = 1'b0;
        up_rdy   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // basic packing
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check("basic_not_yet", 32'(up_vld), 32'd0);
        send(4'h4, 1'b0);
        check_word("basic", 16'h4321, 4'hF, 1'b0);
        idle();
        check("basic_one_cycle", 32'(up_vld), 32'd0);

        // sustained stream, ready never drops
        for (int i = 0; i < 8; i++) begin
            send(4'(i), 1'b0);
            check("stream_rdy", 32'(dwn_rdy), 32'd1);
            if (i == 3) check_word("stream_w0", 16'h3210, 4'hF, 1'b0);
            if (i == 4) check("stream_gap", 32'(up_vld), 32'd0);
        end
        check_word("stream_w1", 16'h7654, 4'hF, 1'b0);
        idle();

        // early flush, next beat starts at lane 0
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        check_word("flush", 16'h00BA, 4'b0011, 1'b1);
        send(4'hC, 1'b0);
        check("flush_drained", 32'(up_vld), 32'd0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check_word("after_flush", 16'h321C, 4'hF, 1'b0);
        idle();

        // back-pressure fills both slots
        up_rdy = 1'b0;
        send(4'h0, 1'b0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check_word("bp_w0", 16'h3210, 4'hF, 1'b0);
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        check_word("bp_hold", 16'h3210, 4'hF, 1'b0);
        send(4'h6, 1'b0);
        check("bp_rdy_before", 32'(dwn_rdy), 32'd1);
        send(4'h7, 1'b0);
        check("bp_rdy_low", 32'(dwn_rdy), 32'd0);
        check_word("bp_hold2", 16'h3210, 4'hF, 1'b0);
        dwn_vld  = 1'b1;
        dwn_data = 4'h8;
        dwn_last = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_still_low", 32'(dwn_rdy), 32'd0);
        check_word("bp_hold3", 16'h3210, 4'hF, 1'b0);
        up_rdy = 1'b1;
        @(negedge clk);
        check_word("bp_w1", 16'h7654, 4'hF, 1'b0);
        check("bp_rdy_back", 32'(dwn_rdy), 32'd1);
        @(negedge clk);
        check("bp_drained", 32'(up_vld), 32'd0);
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        check_word("bp_beat8", 16'hBA98, 4'hF, 1'b0);
        idle();

        // reset mid-word discards the partial word
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        dwn_vld = 1'b0;
        rst     = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst = 1'b1;
        @(negedge clk);
        send(4'h9, 1'b0);
        send(4'h8, 1'b0);
        send(4'h7, 1'b0);
        check("midreset_no_word", 32'(up_vld), 32'd0);
        send(4'h6, 1'b0);
        check_word("midreset", 16'h6789, 4'hF, 1'b0);
        idle();

        // random traffic against a packing scoreboard
        m_data   = '0;
        m_keep   = '0;
        m_cnt    = 0;
        stalled  = 1'b0;
        accepted = 0;
        words    = 0;
        for (int cyc = 0; cyc < 5000 && accepted < 256; cyc++) begin
            dwn_vld  = ($urandom_range(0, 3) != 0);
            dwn_data = 4'($urandom_range(0, 15));
            dwn_last = ($urandom_range(0, 7) == 0);
            up_rdy   = ($urandom_range(0, 3) != 0);
            if (up_vld && up_rdy) begin
                check("rand_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("rand_word", 32'({up_data, up_keep, up_last}), 32'(exp_q.pop_front()));
                end
                words++;
            end
            stalled = up_vld && !up_rdy;
            hold    = {up_data, up_keep, up_last};
            if (dwn_vld && dwn_rdy) begin
                m_data[m_cnt*N +: N] = dwn_data;
                m_keep[m_cnt]        = 1'b1;
                accepted++;
                if (m_cnt == K - 1 || dwn_last) begin
                    exp_q.push_back({m_data, m_keep, dwn_last});
                    m_data = '0;
                    m_keep = '0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            @(negedge clk);
            if (stalled) begin
                check("rand_stable", 32'({up_vld, up_data, up_keep, up_last}), 32'({1'b1, hold}));
            end
        end
        check("rand_accepted", 32'(accepted), 32'd256);
        dwn_vld = 1'b0;
        up_rdy  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (up_vld) begin
                check("drain_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("drain_word", 32'({up_data, up_keep, up_last}), 32'(exp_q.pop_front()));
                end
                words++;
            end
            @(negedge clk);
        end
        check("rand_no_loss", 32'(exp_q.size()), 32'd0);
        check("rand_words_seen", 32'(words > 40), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
